id_hazard_ctrl: RTL and testbench
=================================

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: resetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: fs_to_ds_valid  in  1  fetch stage offers instruction; ds_allowin  out  1  ID can accept.
REQ-004 SHALL have: ds_rj, ds_rk, ds_rd  in  5 each  decoded register numbers of the offered instruction (ds_rd already 1 for bl).
REQ-005 SHALL have: ds_rj_used, ds_rk_used, ds_rd_used  in  1 each  field read as source; ds_ref_we  in  1  writes ds_rd; ds_dram_re  in  1  load.
REQ-006 SHALL have: es_allowin, ms_allowin, ws_allowin  in  1 each  downstream stage accepts.
REQ-007 SHALL have: br_flush  in  1  kill ID occupant and offered instruction.
REQ-008 SHALL have: ds_to_es_valid  out  1  issue; ds_stall  out  1  hazard holding ID.
REQ-009 SHALL have: fwd_sel_src1, fwd_sel_src2  out  2 each  operand source: 0 regfile, 1 EX, 2 MEM, 3 WB.

Function
REQ-010 SHALL latch ds_rj/rk/rd, use and write flags into an ID holding register (ds_valid) when fs_to_ds_valid & ds_allowin & !br_flush.
REQ-011 SHALL keep a 3-slot shadow pipeline {valid, dest[4:0], is_load} for EX, MEM, WB.
REQ-012 SHALL load EX slot from ID on ds_to_es_valid & es_allowin; clear it on es_allowin with no issue; MEM loads from EX on ms_allowin; WB loads from MEM on ws_allowin; slots otherwise hold.
REQ-013 SHALL record a slot valid only if ds_ref_we=1 and dest!=0.
REQ-014 SHALL treat a source as hazard-free when its used flag is 0 or register is 0.
REQ-015 SHALL compute ds_stall combinationally = ds_valid & !br_flush & (any hazard per REQ-025/026).
REQ-016 SHALL drive ds_to_es_valid = ds_valid & !ds_stall & !br_flush; ds_allowin = !ds_valid | (!ds_stall & es_allowin).
REQ-017 SHALL, on br_flush, clear ds_valid at next edge and not capture the offered instruction; flush overrides stall.
REQ-018 SHALL resolve multiple matching slots with youngest priority: EX > MEM > WB.
REQ-019 SHALL hold a stalled instruction's fields unchanged until it issues or is flushed.
REQ-020 SHALL use src2 compare on rk when ds_rk_used, on rd when ds_rd_used (mutually exclusive by decode).

Reset
REQ-021 SHALL, while resetn=0, clear ds_valid and all slot valids asynchronously.
REQ-022 SHALL output during reset: ds_allowin=1, ds_to_es_valid=0, ds_stall=0, fwd_sel_*=0.
REQ-023 SHALL, on reset mid-stall, discard the held instruction; first post-reset edge may capture.

Configuration
REQ-024 SHALL compile forwarding under macro ID_FORWARD_EN.
REQ-025 SHALL, with ID_FORWARD_EN, stall only on EX-slot match with is_load=1 (one-bubble load-use); fwd_sel_* report the matching slot per REQ-018.
REQ-026 SHALL, without ID_FORWARD_EN, stall on any EX/MEM/WB match; fwd_sel_* tied to 0.

Structure
REQ-027 SHALL place fwd_sel encodings (FWD_RF, FWD_EX, FWD_MEM, FWD_WB) and the slot typedef in shared package id_ctrl_pkg.
REQ-028 SHALL instantiate sub-module src_hazard_cmp (one source vs three slots -> hit, load_hit, sel), twice.

Verification
REQ-029 add r4 then add r5,r4,r6 back-to-back, FORWARD_EN -> no stall, fwd_sel_src1=1.
REQ-030 ld.w r4 then add r5,r4,r6, FORWARD_EN -> ds_stall=1 one cycle, then issue with fwd_sel_src1=2.
REQ-031 same as REQ-029 without ID_FORWARD_EN -> ds_stall 3 cycles (EX,MEM,WB), issue with fwd_sel=0.
REQ-032 add r0,... then add r5,r0,r0 -> no stall; st.w reading rd=r4 after ld r4 -> src2 load-use stall.
REQ-033 br_flush asserted during load-use stall -> ds_stall=0, ds_to_es_valid=0, ds_valid=0 next cycle.
REQ-034 resetn low while stalled with es_allowin=0 -> ds_allowin=1, all outputs at reset values immediately.

Source files
------------

// File: rtl/id_ctrl_pkg.sv
// id_ctrl_pkg: shared types for the ID-stage hazard controller.
// Holds the operand-source encoding and the shadow-pipeline slot layout.
package id_ctrl_pkg;

  // Where an operand is taken from when the instruction leaves ID.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  // One shadow entry per downstream stage: does it write a register, which one, is it a load.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } slot_t;

  // r0 is hard-wired zero, so a write to it never creates a dependency.
  function automatic slot_t make_slot(input logic we, input logic [4:0] dest, input logic is_load);
    slot_t s;
    s.valid   = we & (dest != 5'd0);
    s.dest    = dest;
    s.is_load = is_load;
    return s;
  endfunction

endpackage

// File: rtl/src_hazard_cmp.sv
// src_hazard_cmp: compares one source register of the ID instruction
// against the EX/MEM/WB shadow slots; the youngest matching slot wins.
module src_hazard_cmp
  import id_ctrl_pkg::*;
(
  input  logic       src_used,
  input  logic [4:0] src_reg,
  input  slot_t      ex_slot,
  input  slot_t      mem_slot,
  input  slot_t      wb_slot,
  output logic       hit,
  output logic       load_hit,
  output logic [1:0] sel
);

  logic src_live;
  logic ex_match;
  logic mem_match;
  logic wb_match;
  logic unused_load_bits;

  assign src_live  = src_used & (src_reg != 5'd0);
  assign ex_match  = src_live & ex_slot.valid  & (ex_slot.dest  == src_reg);
  assign mem_match = src_live & mem_slot.valid & (mem_slot.dest == src_reg);
  assign wb_match  = src_live & wb_slot.valid  & (wb_slot.dest  == src_reg);

  assign hit      = ex_match | mem_match | wb_match;
  assign load_hit = ex_match & ex_slot.is_load;

  // Only the EX slot can produce a load-use bubble; older load data is already available.
  assign unused_load_bits = mem_slot.is_load ^ wb_slot.is_load;

  // Pick the youngest producer so the most recent value of the register is used.
  always_comb begin
    sel = FWD_RF;
    if (ex_match)       sel = FWD_EX;
    else if (mem_match) sel = FWD_MEM;
    else if (wb_match)  sel = FWD_WB;
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage holding register, EX/MEM/WB shadow pipeline and
// RAW hazard / forwarding control.
// Optional feature macro: ID_FORWARD_EN (operand forwarding with one-bubble
// load-use stall). Without it every in-flight dependency stalls until WB retires.
module id_hazard_ctrl
  import id_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       fs_to_ds_valid,
  output logic       ds_allowin,
  input  logic [4:0] ds_rj,
  input  logic [4:0] ds_rk,
  input  logic [4:0] ds_rd,
  input  logic       ds_rj_used,
  input  logic       ds_rk_used,
  input  logic       ds_rd_used,
  input  logic       ds_ref_we,
  input  logic       ds_dram_re,
  input  logic       es_allowin,
  input  logic       ms_allowin,
  input  logic       ws_allowin,
  input  logic       br_flush,
  output logic       ds_to_es_valid,
  output logic       ds_stall,
  output logic [1:0] fwd_sel_src1,
  output logic [1:0] fwd_sel_src2
);

  logic       ds_valid;
  logic [4:0] id_rj;
  logic [4:0] id_rk;
  logic [4:0] id_rd;
  logic       id_rj_used;
  logic       id_rk_used;
  logic       id_rd_used;
  logic       id_ref_we;
  logic       id_dram_re;

  slot_t      ex_slot;
  slot_t      mem_slot;
  slot_t      wb_slot;
  slot_t      id_slot;

  logic       ds_capture;
  logic       src2_used;
  logic [4:0] src2_reg;
  logic       hit1;
  logic       hit2;
  logic       load_hit1;
  logic       load_hit2;
  logic [1:0] sel1;
  logic [1:0] sel2;

  assign ds_capture = fs_to_ds_valid & ds_allowin & ~br_flush;

  // Stores use rd as their second source, other instructions use rk.
  assign src2_used = id_rk_used | id_rd_used;
  assign src2_reg  = id_rk_used ? id_rk : id_rd;

  assign id_slot = make_slot(id_ref_we, id_rd, id_dram_re);

  // Occupancy of ID: a flush empties it, otherwise it refills whenever it may accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         ds_valid <= 1'b0;
    else if (br_flush)   ds_valid <= 1'b0;
    else if (ds_allowin) ds_valid <= fs_to_ds_valid;
  end

  // Decoded fields of the ID occupant; they stay frozen while it is stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_rj      <= 5'd0;
      id_rk      <= 5'd0;
      id_rd      <= 5'd0;
      id_rj_used <= 1'b0;
      id_rk_used <= 1'b0;
      id_rd_used <= 1'b0;
      id_ref_we  <= 1'b0;
      id_dram_re <= 1'b0;
    end else if (ds_capture) begin
      id_rj      <= ds_rj;
      id_rk      <= ds_rk;
      id_rd      <= ds_rd;
      id_rj_used <= ds_rj_used;
      id_rk_used <= ds_rk_used;
      id_rd_used <= ds_rd_used;
      id_ref_we  <= ds_ref_we;
      id_dram_re <= ds_dram_re;
    end
  end

  // Shadow of the downstream pipeline, advancing with each stage's own allowin.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else begin
      if (es_allowin) ex_slot  <= ds_to_es_valid ? id_slot : slot_t'('0);
      if (ms_allowin) mem_slot <= ex_slot;
      if (ws_allowin) wb_slot  <= mem_slot;
    end
  end

  src_hazard_cmp u_cmp_src1 (
    .src_used (id_rj_used),
    .src_reg  (id_rj),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .wb_slot  (wb_slot),
    .hit      (hit1),
    .load_hit (load_hit1),
    .sel      (sel1)
  );

  src_hazard_cmp u_cmp_src2 (
    .src_used (src2_used),
    .src_reg  (src2_reg),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .wb_slot  (wb_slot),
    .hit      (hit2),
    .load_hit (load_hit2),
    .sel      (sel2)
  );

`ifdef ID_FORWARD_EN
  logic unused_hits;
  assign unused_hits  = hit1 ^ hit2;
  assign ds_stall     = ds_valid & ~br_flush & (load_hit1 | load_hit2);
  assign fwd_sel_src1 = sel1;
  assign fwd_sel_src2 = sel2;
`else
  logic unused_fwd;
  assign unused_fwd   = ^{load_hit1, load_hit2, sel1, sel2};
  assign ds_stall     = ds_valid & ~br_flush & (hit1 | hit2);
  assign fwd_sel_src1 = FWD_RF;
  assign fwd_sel_src2 = FWD_RF;
`endif

  assign ds_to_es_valid = ds_valid & ~ds_stall & ~br_flush;
  assign ds_allowin     = ~ds_valid | (~ds_stall & es_allowin);

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed scenarios plus randomized traffic for id_hazard_ctrl,
// checked against a behavioural model of in-flight register writers.
module tb_id_hazard_ctrl;

`ifdef ID_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    bit       fs;
    bit [4:0] rj;
    bit [4:0] rk;
    bit [4:0] rd;
    bit       rj_u;
    bit       rk_u;
    bit       rd_u;
    bit       we;
    bit       ld;
    bit       es;
    bit       ms;
    bit       ws;
    bit       flush;
  } stim_t;

  logic       clk;
  logic       resetn;
  logic       fs_to_ds_valid;
  logic       ds_allowin;
  logic [4:0] ds_rj;
  logic [4:0] ds_rk;
  logic [4:0] ds_rd;
  logic       ds_rj_used;
  logic       ds_rk_used;
  logic       ds_rd_used;
  logic       ds_ref_we;
  logic       ds_dram_re;
  logic       es_allowin;
  logic       ms_allowin;
  logic       ws_allowin;
  logic       br_flush;
  logic       ds_to_es_valid;
  logic       ds_stall;
  logic [1:0] fwd_sel_src1;
  logic [1:0] fwd_sel_src2;

  int checks = 0;
  int failures = 0;

  stim_t cur;
  // Model: instruction sitting in ID, and writers 1, 2, 3 stages ahead of it.
  bit    m_id_valid;
  stim_t m_id;
  bit    m_wv[3];
  int    m_wd[3];
  bit    m_wl[3];
  bit    exp_stall;
  bit    exp_issue;
  bit    exp_allowin;

  id_hazard_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .fs_to_ds_valid (fs_to_ds_valid),
    .ds_allowin     (ds_allowin),
    .ds_rj          (ds_rj),
    .ds_rk          (ds_rk),
    .ds_rd          (ds_rd),
    .ds_rj_used     (ds_rj_used),
    .ds_rk_used     (ds_rk_used),
    .ds_rd_used     (ds_rd_used),
    .ds_ref_we      (ds_ref_we),
    .ds_dram_re     (ds_dram_re),
    .es_allowin     (es_allowin),
    .ms_allowin     (ms_allowin),
    .ws_allowin     (ws_allowin),
    .br_flush       (br_flush),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_stall       (ds_stall),
    .fwd_sel_src1   (fwd_sel_src1),
    .fwd_sel_src2   (fwd_sel_src2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic stim_t idle(input bit es, input bit flush);
    stim_t s;
    s.fs = 1'b0; s.rj = '0; s.rk = '0; s.rd = '0;
    s.rj_u = 1'b0; s.rk_u = 1'b0; s.rd_u = 1'b0; s.we = 1'b0; s.ld = 1'b0;
    s.es = es; s.ms = 1'b1; s.ws = 1'b1; s.flush = flush;
    return s;
  endfunction

  function automatic stim_t ins(input int rd, input int rj, input int rk, input bit rj_u,
                                input bit rk_u, input bit rd_u, input bit we, input bit ld);
    stim_t s;
    s = idle(1'b1, 1'b0);
    s.fs = 1'b1; s.rd = 5'(rd); s.rj = 5'(rj); s.rk = 5'(rk);
    s.rj_u = rj_u; s.rk_u = rk_u; s.rd_u = rd_u; s.we = we; s.ld = ld;
    return s;
  endfunction

  function automatic stim_t randomStim();
    stim_t s;
    int k;
    s.fs    = ($urandom_range(3) != 0);
    s.rj    = 5'($urandom_range(3));
    s.rk    = 5'($urandom_range(3));
    s.rd    = 5'($urandom_range(3));
    s.rj_u  = ($urandom_range(1) == 1);
    k       = int'($urandom_range(2));
    s.rk_u  = (k == 1);
    s.rd_u  = (k == 2);
    s.we    = ($urandom_range(3) != 0);
    s.ld    = ($urandom_range(2) == 0);
    s.es    = ($urandom_range(4) != 0);
    s.ms    = ($urandom_range(4) != 0);
    s.ws    = ($urandom_range(4) != 0);
    s.flush = ($urandom_range(9) == 0);
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    cur            = s;
    fs_to_ds_valid = s.fs;
    ds_rj          = s.rj;
    ds_rk          = s.rk;
    ds_rd          = s.rd;
    ds_rj_used     = s.rj_u;
    ds_rk_used     = s.rk_u;
    ds_rd_used     = s.rd_u;
    ds_ref_we      = s.we;
    ds_dram_re     = s.ld;
    es_allowin     = s.es;
    ms_allowin     = s.ms;
    ws_allowin     = s.ws;
    br_flush       = s.flush;
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  task automatic checkSel(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    m_id_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_wv[i] = 1'b0; m_wd[i] = 0; m_wl[i] = 1'b0;
    end
  endtask

  // Youngest in-flight writer of register r decides both stall and operand source.
  function automatic void lookup(input bit used, input int r, output bit stall, output logic [1:0] sel);
    int found;
    found = -1;
    stall = 1'b0;
    sel   = 2'd0;
    if (used && r != 0) begin
      for (int s = 0; s < 3; s++)
        if (found < 0 && m_wv[s] && m_wd[s] == r) found = s;
    end
    if (found >= 0) begin
      if (FWD) begin
        sel   = 2'(found + 1);
        stall = (found == 0) && m_wl[0];
      end else begin
        stall = 1'b1;
      end
    end
  endfunction

  task automatic checkOutput();
    bit st1, st2;
    logic [1:0] s1, s2;
    lookup(m_id.rj_u, int'(m_id.rj), st1, s1);
    lookup(m_id.rk_u || m_id.rd_u, m_id.rk_u ? int'(m_id.rk) : int'(m_id.rd), st2, s2);
    exp_stall   = m_id_valid && !cur.flush && (st1 || st2);
    exp_issue   = m_id_valid && !exp_stall && !cur.flush;
    exp_allowin = !m_id_valid || (!exp_stall && cur.es);
    checkBit("model_stall", ds_stall, exp_stall);
    checkBit("model_issue", ds_to_es_valid, exp_issue);
    checkBit("model_allowin", ds_allowin, exp_allowin);
    if (m_id_valid) begin
      checkSel("model_sel1", fwd_sel_src1, s1);
      checkSel("model_sel2", fwd_sel_src2, s2);
    end
  endtask

  task automatic advanceModel();
    if (cur.ws) begin m_wv[2] = m_wv[1]; m_wd[2] = m_wd[1]; m_wl[2] = m_wl[1]; end
    if (cur.ms) begin m_wv[1] = m_wv[0]; m_wd[1] = m_wd[0]; m_wl[1] = m_wl[0]; end
    if (cur.es) begin
      m_wv[0] = exp_issue && m_id.we && m_id.rd != 0;
      m_wd[0] = int'(m_id.rd);
      m_wl[0] = m_id.ld;
    end
    if (cur.flush) m_id_valid = 1'b0;
    else if (exp_allowin) begin
      m_id_valid = cur.fs;
      if (cur.fs) m_id = cur;
    end
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    applyStimulus(s);
    @(negedge clk);
    checkOutput();
    advanceModel();
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(idle(1'b1, 1'b0));
  endtask

  initial begin
    m_id = idle(1'b1, 1'b0);
    resetModel();
    resetn = 1'b0;
    applyStimulus(ins(4, 1, 2, 1, 1, 0, 1, 0));
    #12;
    checkBit("rst_allowin", ds_allowin, 1'b1);
    checkBit("rst_issue", ds_to_es_valid, 1'b0);
    checkBit("rst_stall", ds_stall, 1'b0);
    checkSel("rst_sel1", fwd_sel_src1, 2'd0);
    checkSel("rst_sel2", fwd_sel_src2, 2'd0);
    @(posedge clk);
    #2;
    checkBit("rst_nocapture", ds_to_es_valid, 1'b0);
    applyStimulus(idle(1'b1, 1'b0));
    @(negedge clk);
    resetn = 1'b1;

    // add r4 ; add r5,r4,r6 back-to-back
    step(ins(4, 1, 2, 1, 1, 0, 1, 0));
    checkBit("alu_first_allowin", ds_allowin, 1'b1);
    step(ins(5, 4, 6, 1, 1, 0, 1, 0));
    checkBit("alu_first_issue", ds_to_es_valid, 1'b1);
`ifdef ID_FORWARD_EN
    step(idle(1'b1, 1'b0));
    checkBit("alu_fwd_nostall", ds_stall, 1'b0);
    checkSel("alu_fwd_sel1", fwd_sel_src1, 2'd1);
`else
    for (int i = 0; i < 3; i++) begin
      step(idle(1'b1, 1'b0));
      checkBit("alu_nofwd_stall", ds_stall, 1'b1);
    end
    step(idle(1'b1, 1'b0));
    checkBit("alu_nofwd_issue", ds_to_es_valid, 1'b1);
    checkSel("alu_nofwd_sel1", fwd_sel_src1, 2'd0);
`endif
    drain();

    // ld.w r4 ; add r5,r4,r6
    step(ins(4, 1, 0, 1, 0, 0, 1, 1));
    step(ins(5, 4, 6, 1, 1, 0, 1, 0));
    checkBit("ld_issue", ds_to_es_valid, 1'b1);
`ifdef ID_FORWARD_EN
    step(idle(1'b1, 1'b0));
    checkBit("lduse_stall", ds_stall, 1'b1);
    step(idle(1'b1, 1'b0));
    checkBit("lduse_issue", ds_to_es_valid, 1'b1);
    checkSel("lduse_sel1", fwd_sel_src1, 2'd2);
`else
    for (int i = 0; i < 3; i++) begin
      step(idle(1'b1, 1'b0));
      checkBit("lduse_nofwd_stall", ds_stall, 1'b1);
    end
    step(idle(1'b1, 1'b0));
    checkBit("lduse_nofwd_issue", ds_to_es_valid, 1'b1);
`endif
    drain();

    // r0 never creates a dependency
    step(ins(0, 1, 2, 1, 1, 0, 1, 0));
    step(ins(5, 0, 0, 1, 1, 0, 1, 0));
    step(idle(1'b1, 1'b0));
    checkBit("r0_nostall", ds_stall, 1'b0);
    checkBit("r0_issue", ds_to_es_valid, 1'b1);
    drain();

    // ld r4 ; st.w r4 (rd as source) stalls on src2, then flushed while stalled
    step(ins(4, 1, 0, 1, 0, 0, 1, 1));
    step(ins(4, 7, 0, 1, 0, 1, 0, 0));
    step(idle(1'b0, 1'b0));
    checkBit("st_src2_stall", ds_stall, 1'b1);
    checkBit("st_src2_allowin", ds_allowin, 1'b0);
    step(idle(1'b0, 1'b1));
    checkBit("flush_nostall", ds_stall, 1'b0);
    checkBit("flush_noissue", ds_to_es_valid, 1'b0);
    step(idle(1'b0, 1'b0));
    checkBit("flush_emptied", ds_allowin, 1'b1);
    checkBit("flush_noissue_after", ds_to_es_valid, 1'b0);
    drain();

    // asynchronous reset while stalled with EX blocked
    step(ins(4, 1, 0, 1, 0, 0, 1, 1));
    step(ins(5, 4, 6, 1, 1, 0, 1, 0));
    step(idle(1'b0, 1'b0));
    checkBit("prerst_stall", ds_stall, 1'b1);
    #1;
    resetn = 1'b0;
    #1;
    checkBit("midrst_allowin", ds_allowin, 1'b1);
    checkBit("midrst_issue", ds_to_es_valid, 1'b0);
    checkBit("midrst_stall", ds_stall, 1'b0);
    checkSel("midrst_sel1", fwd_sel_src1, 2'd0);
    checkSel("midrst_sel2", fwd_sel_src2, 2'd0);
    resetModel();
    @(posedge clk);
    #1;
    applyStimulus(ins(9, 1, 2, 1, 1, 0, 1, 0));
    @(negedge clk);
    resetn = 1'b1;
    checkOutput();
    advanceModel();
    step(idle(1'b1, 1'b0));
    checkBit("postrst_capture_issue", ds_to_es_valid, 1'b1);
    drain();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) step(randomStim());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
